mem_align_seq: RTL and testbench

Load/store sequencer between the execute stage and `data_memory`. Accepts one load/store request per handshake, issues one or more single-word accesses to `data_memory` over its `addr`/`wr_en`/`funct3`/`data_in`/`data_out` port set, and returns extended load data. Misaligned and word-crossing accesses are split into aligned word reads and read-modify-write word stores, since `data_memory` only supports naturally aligned accesses.

---
 rtl/mem_align_seq_if.sv | 27 ++
 rtl/mem_align_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_align_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_seq_if.sv
// mem_align_seq_if: request/response handshake between the execute stage and
// the load/store sequencer. The requester uses the master modport and the
// sequencer uses the slave modport.
interface mem_align_seq_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/mem_align_seq.sv
// mem_align_seq: load/store sequencer in front of an aligned-only data_memory.
// Aligned requests go straight through in one access; misaligned and
// word-crossing requests are split into two aligned word reads, followed for
// stores by two read-modify-write word stores.
// Build option: define MISALIGN_EN to build the split path. Without it,
// misaligned requests are answered with resp_error and never touch memory.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// ACC    | single aligned access straight to data_memory
// RD_LO  | read word A (split path)
// RD_HI  | read word A+1, build the load result (split path)
// WR_LO  | store merged low word to word A (split path)
// WR_HI  | store merged high word to word A+1 (split path)
// ERR    | illegal request, no memory access
// RESP   | one-cycle response pulse
module mem_align_seq #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    mem_align_seq_if.slave    bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [2:0]        mem_funct3,
    output logic [WIDTH-1:0]  mem_data_in,
    input  logic [WIDTH-1:0]  mem_data_out
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;
`ifdef MISALIGN_EN
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_RD_HI = 3'd3;
    localparam logic [2:0] S_WR_LO = 3'd4;
    localparam logic [2:0] S_WR_HI = 3'd5;
    localparam logic [2:0] F3_W    = 3'b010;
`endif

    logic [2:0]        state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              err_q;
    logic              accept;
    logic              req_illegal;
    logic              req_misaligned;

    assign accept         = bus.req_valid && (state == S_IDLE);
    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = err_q;

    // Classify the incoming request: illegal encoding, or needing the split path.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (bus.req_we)
            req_illegal = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                            bus.req_funct3 == 3'b010);
        else
            req_illegal = (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                           bus.req_funct3 == 3'b111);
        case (bus.req_funct3[1:0])
            2'b01:   req_misaligned = bus.req_addr[0];
            2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

`ifdef MISALIGN_EN
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [ADDR_W-3:0]  word_a, word_b;
    logic [4:0]         sh;
    logic [2*WIDTH-1:0] ld_pair, st_pair, st_mask, st_data, merged;
    logic [WIDTH-1:0]   ld_word, ld_ext;

    // Word A+1 wraps naturally inside the word-index width.
    assign word_a  = addr_q[ADDR_W-1:2];
    assign word_b  = word_a + {{(ADDR_W-3){1'b0}}, 1'b1};
    assign sh      = {addr_q[1:0], 3'b000};

    // The high word is still on mem_data_out when the load result is built.
    assign ld_pair = {mem_data_out, lo_q};
    assign ld_word = WIDTH'(ld_pair >> sh);

    assign st_pair = {hi_q, lo_q};
    assign st_mask = (f3_q[0] ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF) << sh;
    assign st_data = {{WIDTH{1'b0}}, wdata_q} << sh;
    assign merged  = (st_pair & ~st_mask) | (st_data & st_mask);

    // Truncate and extend the shifted load to the requested width.
    always_comb begin
        case (f3_q)
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b101:  ld_ext = {16'h0000, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // Capture both words of a split access.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (state == S_RD_LO) lo_q <= mem_data_out;
            if (state == S_RD_HI) hi_q <= mem_data_out;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_illegal)
                        state_nxt = S_ERR;
                    else if (req_misaligned)
`ifdef MISALIGN_EN
                        state_nxt = S_RD_LO;
`else
                        state_nxt = S_ERR;
`endif
                    else
                        state_nxt = S_ACC;
                end
            end
            S_ACC, S_ERR: state_nxt = S_RESP;
`ifdef MISALIGN_EN
            S_RD_LO:      state_nxt = S_RD_HI;
            S_RD_HI:      state_nxt = we_q ? S_WR_LO : S_RESP;
            S_WR_LO:      state_nxt = S_WR_HI;
            S_WR_HI:      state_nxt = S_RESP;
`endif
            S_RESP:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // State, request latch, and response registers updated on entry to RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            case (state)
                S_ACC: begin
                    rdata_q <= we_q ? '0 : mem_data_out;
                    err_q   <= 1'b0;
                end
                S_ERR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
`ifdef MISALIGN_EN
                S_RD_HI: begin
                    if (!we_q) begin
                        rdata_q <= ld_ext;
                        err_q   <= 1'b0;
                    end
                end
                S_WR_HI: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Memory port drive; idle states park every output at zero and reset
    // blocks any write in flight.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_funct3  = 3'b000;
        mem_data_in = '0;
        case (state)
            S_ACC: begin
                mem_addr    = addr_q;
                mem_wr_en   = we_q;
                mem_funct3  = f3_q;
                mem_data_in = wdata_q;
            end
`ifdef MISALIGN_EN
            S_RD_LO: begin
                mem_addr   = {word_a, 2'b00};
                mem_funct3 = F3_W;
            end
            S_RD_HI: begin
                mem_addr   = {word_b, 2'b00};
                mem_funct3 = F3_W;
            end
            S_WR_LO: begin
                mem_addr    = {word_a, 2'b00};
                mem_wr_en   = 1'b1;
                mem_funct3  = F3_W;
                mem_data_in = merged[WIDTH-1:0];
            end
            S_WR_HI: begin
                mem_addr    = {word_b, 2'b00};
                mem_wr_en   = 1'b1;
                mem_funct3  = F3_W;
                mem_data_in = merged[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
        if (rst) mem_wr_en = 1'b0;
    end
endmodule

// File: tb/tb_mem_align_seq.sv
// tb_mem_align_seq: directed bench for mem_align_seq with a behavioural
// data_memory per instance. A 10-bit-address instance covers the main
// function; a 6-bit-address instance covers the top-word wrap.
`timescale 1ns/1ps
module tb_mem_align_seq;
`ifdef MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    mem_align_seq_if #(.WIDTH(32), .ADDR_W(10)) bus_b ();
    mem_align_seq_if #(.WIDTH(32), .ADDR_W(6))  bus_s ();

    logic        vb = 1'b0, vs = 1'b0, req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b000;
    logic [9:0]  req_addr = 10'h000;
    logic [31:0] req_wdata = 32'h0;

    assign bus_b.req_valid  = vb;
    assign bus_b.req_we     = req_we;
    assign bus_b.req_funct3 = req_f3;
    assign bus_b.req_addr   = req_addr;
    assign bus_b.req_wdata  = req_wdata;
    assign bus_s.req_valid  = vs;
    assign bus_s.req_we     = req_we;
    assign bus_s.req_funct3 = req_f3;
    assign bus_s.req_addr   = req_addr[5:0];
    assign bus_s.req_wdata  = req_wdata;

    logic [9:0]  mb_addr;
    logic        mb_we;
    logic [2:0]  mb_f3;
    logic [31:0] mb_din, mb_dout;
    logic [5:0]  ms_addr;
    logic        ms_we;
    logic [2:0]  ms_f3;
    logic [31:0] ms_din, ms_dout;

    mem_align_seq #(.WIDTH(32), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .mem_addr(mb_addr), .mem_wr_en(mb_we), .mem_funct3(mb_f3),
        .mem_data_in(mb_din), .mem_data_out(mb_dout)
    );

    mem_align_seq #(.WIDTH(32), .ADDR_W(6)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s),
        .mem_addr(ms_addr), .mem_wr_en(ms_we), .mem_funct3(ms_f3),
        .mem_data_in(ms_din), .mem_data_out(ms_dout)
    );

    // Behavioural data_memory: combinational extended read, byte-lane writes.
    logic [31:0] mem_b [0:255];
    logic [31:0] mem_s [0:15];
    logic        loaded = 1'b0;
    int          wr_cnt_b = 0, wr_cnt_s = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign mb_dout = mem_read(mem_b[mb_addr[9:2]], mb_addr[1:0], mb_f3);
    assign ms_dout = mem_read(mem_s[ms_addr[5:2]], ms_addr[1:0], ms_f3);

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'h0;
            for (int i = 0; i < 16; i++)  mem_s[i] <= 32'h0;
            mem_b[0]  <= 32'h44332211;
            mem_b[1]  <= 32'h88776655;
            mem_b[2]  <= 32'h000000CC;
            mem_s[0]  <= 32'h44332211;
            mem_s[15] <= 32'hDDCCBBAA;
            loaded    <= 1'b1;
        end else begin
            if (mb_we) begin
                wr_cnt_b <= wr_cnt_b + 1;
                case (mb_f3[1:0])
                    2'b00:   mem_b[mb_addr[9:2]][{mb_addr[1:0], 3'b000} +: 8] <= mb_din[7:0];
                    2'b01:   mem_b[mb_addr[9:2]][{mb_addr[1], 4'b0000} +: 16] <= mb_din[15:0];
                    default: mem_b[mb_addr[9:2]] <= mb_din;
                endcase
            end
            if (ms_we) begin
                wr_cnt_s <= wr_cnt_s + 1;
                mem_s[ms_addr[5:2]] <= ms_din;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: expectation pushed on drive, popped when resp_valid shows.
    task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                          input logic [9:0] a, input logic [31:0] wd,
                          input logic [31:0] x_rdata, input logic x_err,
                          input int x_lat, input int x_wr, input string tag);
        exp_t e;
        int   n, lat, wr0;
        bit   got;
        e.rdata = x_rdata;
        e.err   = x_err;
        e.lat   = x_lat;
        e.wr    = x_wr;
        sb.push_back(e);
        n = 0;
        while (!(sel ? bus_s.req_ready : bus_b.req_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " ready_idle"}, sel ? bus_s.req_ready : bus_b.req_ready, 1);
        req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        if (sel) vs = 1'b1; else vb = 1'b1;
        wr0 = sel ? wr_cnt_s : wr_cnt_b;
        @(posedge clk); #1;
        vb = 1'b0; vs = 1'b0;
        chk({tag, " ready_busy"}, sel ? bus_s.req_ready : bus_b.req_ready, 0);
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 12) begin
            if (sel ? bus_s.resp_valid : bus_b.resp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $error("FAIL %s timeout: observed no resp_valid by cycle %0d expected at cycle %0d",
                   tag, lat, e.lat);
        end else begin
            chk({tag, " rdata"}, sel ? bus_s.resp_rdata : bus_b.resp_rdata, e.rdata);
            chk({tag, " error"}, sel ? bus_s.resp_error : bus_b.resp_error, e.err);
            chk({tag, " latency"}, lat, e.lat);
            chk({tag, " writes"}, (sel ? wr_cnt_s : wr_cnt_b) - wr0, e.wr);
            @(posedge clk); #1;
            chk({tag, " pulse"}, sel ? bus_s.resp_valid : bus_b.resp_valid, 0);
            chk({tag, " hold"}, sel ? bus_s.resp_rdata : bus_b.resp_rdata, e.rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed time %0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en_in_reset", mb_we, 0);
        chk("rst_ready_in_reset", bus_b.req_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_valid", bus_b.resp_valid, 0);
        chk("rst_resp_rdata", bus_b.resp_rdata, 0);
        chk("rst_resp_error", bus_b.resp_error, 0);
        chk("rst_mem_addr", mb_addr, 0);
        chk("rst_mem_wr_en", mb_we, 0);
        chk("rst_mem_funct3", mb_f3, 0);
        chk("rst_mem_data_in", mb_din, 0);
        chk("rst_small_ready", bus_s.req_ready, 1);

        do_req(0, 0, LW,  10'h004, 0, 32'h88776655, 0, 2, 0, "lw_004");
        do_req(0, 0, LW,  10'h001, 0, MIS ? 32'h55443322 : 32'h0, !MIS, MIS ? 3 : 2, 0, "lw_001");
        do_req(0, 0, LH,  10'h003, 0, MIS ? 32'h00005544 : 32'h0, !MIS, MIS ? 3 : 2, 0, "lh_003");
        do_req(0, 0, LH,  10'h007, 0, MIS ? 32'hFFFFCC88 : 32'h0, !MIS, MIS ? 3 : 2, 0, "lh_007");
        do_req(0, 0, LHU, 10'h007, 0, MIS ? 32'h0000CC88 : 32'h0, !MIS, MIS ? 3 : 2, 0, "lhu_007");
        do_req(0, 0, LB,  10'h006, 0, 32'h00000077, 0, 2, 0, "lb_006");
        do_req(0, 0, LB,  10'h007, 0, 32'hFFFFFF88, 0, 2, 0, "lb_007");
        do_req(0, 0, LBU, 10'h005, 0, 32'h00000066, 0, 2, 0, "lbu_005");
        do_req(0, 0, 3'b011, 10'h000, 0, 32'h0, 1, 2, 0, "ld_f3_011");
        do_req(0, 1, 3'b011, 10'h000, 32'h12345678, 32'h0, 1, 2, 0, "st_f3_011");
        do_req(0, 1, SB,  10'h009, 32'h000000AB, 32'h0, 0, 2, 1, "sb_009");
        do_req(0, 0, LW,  10'h008, 0, 32'h0000ABCC, 0, 2, 0, "lw_008");
        do_req(0, 1, SH,  10'h00E, 32'hFFFFBEEF, 32'h0, 0, 2, 1, "sh_00e");
        do_req(0, 0, LH,  10'h00E, 0, 32'hFFFFBEEF, 0, 2, 0, "lh_00e");
        do_req(0, 0, LHU, 10'h00E, 0, 32'h0000BEEF, 0, 2, 0, "lhu_00e");
        do_req(0, 1, SW,  10'h002, 32'hA1B2C3D4, 32'h0, !MIS, MIS ? 5 : 2, MIS ? 2 : 0, "sw_002");
        chk("sw_002 word0", mem_b[0], MIS ? 32'hC3D42211 : 32'h44332211);
        chk("sw_002 word1", mem_b[1], MIS ? 32'h8877A1B2 : 32'h88776655);
        do_req(0, 0, LW,  10'h002, 0, MIS ? 32'hA1B2C3D4 : 32'h0, !MIS, MIS ? 3 : 2, 0, "lw_002");
        do_req(0, 0, LW,  10'h000, 0, MIS ? 32'hC3D42211 : 32'h44332211, 0, 2, 0, "lw_000");

        do_req(1, 0, LW,  10'h03C, 0, 32'hDDCCBBAA, 0, 2, 0, "small_lw_03c");
        do_req(1, 0, LW,  10'h03D, 0, MIS ? 32'h11DDCCBB : 32'h0, !MIS, MIS ? 3 : 2, 0, "small_lw_03d");

`ifdef MISALIGN_EN
        req_we = 1'b1; req_f3 = SW; req_addr = 10'h006; req_wdata = 32'h11223344;
        vb = 1'b1;
        @(posedge clk); #1;
        vb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid wr_lo wr_en", mb_we, 1);
        chk("rstmid wr_lo addr", mb_addr, 10'h004);
        @(posedge clk); #1;
        chk("rstmid wr_hi addr", mb_addr, 10'h008);
        rst = 1'b1;
        #1;
        chk("rstmid wr_hi wr_en", mb_we, 0);
        @(posedge clk); #1;
        chk("rstmid ready", bus_b.req_ready, 1);
        rst = 1'b0;
        chk("rstmid word1", mem_b[1], 32'h3344A1B2);
        chk("rstmid word2", mem_b[2], 32'h0000ABCC);
        chk("rstmid rdata", bus_b.resp_rdata, 0);
`else
        req_we = 1'b1; req_f3 = SW; req_addr = 10'h00C; req_wdata = 32'hDEADBEEF;
        vb = 1'b1;
        @(posedge clk); #1;
        vb = 1'b0;
        chk("rstmid acc wr_en", mb_we, 1);
        rst = 1'b1;
        #1;
        chk("rstmid acc wr_en_rst", mb_we, 0);
        @(posedge clk); #1;
        chk("rstmid ready", bus_b.req_ready, 1);
        rst = 1'b0;
        chk("rstmid word3", mem_b[3], 32'hBEEF0000);
        chk("rstmid rdata", bus_b.resp_rdata, 0);
`endif
        do_req(0, 0, LW, 10'h004, 0, MIS ? 32'h3344A1B2 : 32'h88776655, 0, 2, 0, "lw_004_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
